// File: rtl/data_ram_master_pkg.sv
// Shared state encoding, default constants and helpers for the data RAM master.
`timescale 1ns/1ps
package data_ram_master_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WRITE  = 3'd1,
        RD_REQ = 3'd2,
        RD_CAP = 3'd3,
        RD_REL = 3'd4,
        RESP   = 3'd5
    } state_t;

    localparam int DEFAULT_TIMEOUT = 16;

    // Bits needed to hold counts 0 .. maxCount-1.
    function automatic int cntWidth(input int maxCount);
        return (maxCount <= 2) ? 1 : $clog2(maxCount);
    endfunction

endpackage

// File: rtl/data_ram_master_timeout.sv
// Clearable saturating cycle counter; expired_o is high once TIMEOUT-1 is reached.
`timescale 1ns/1ps
module data_ram_master_timeout
    import data_ram_master_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic count_en_i,
    output logic expired_o
);

    localparam int CW = cntWidth(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q, count_d;

    // Clear has priority so a new load always starts from zero.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (count_en_i && (count_q != LAST)) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == LAST);

endmodule

// File: rtl/data_ram_master.sv
// Load/store initiator for the data RAM. Define DATA_RAM_MASTER_TIMEOUT_EN to bound
// the wait for dataReady and report rsp_err on expiry.
`timescale 1ns/1ps
module data_ram_master
    import data_ram_master_pkg::*;
#(
    parameter int width   = 8,
    parameter int length  = 8,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [length-1:0] req_addr,
    input  logic [width-1:0]  req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [width-1:0]  rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic              ram_writeEnable,
    output logic              ram_readEnable,
    output logic [length-1:0] ram_addr,
    output logic [length-1:0] ram_readAddr,
    output logic [width-1:0]  ram_writeData,
    input  logic              ram_dataReady,
    input  logic [width-1:0]  ram_readData
);

    state_t            state_q;
    logic              req_ready_q, rsp_valid_q, rsp_err_q, busy_q;
    logic              we_q, re_q;
    logic [width-1:0]  rsp_rdata_q, wdata_q;
    logic [length-1:0] waddr_q, raddr_q;
    logic              accept;
    logic              expired;

    assign accept = (state_q == IDLE) && req_valid && req_ready_q;

`ifdef DATA_RAM_MASTER_TIMEOUT_EN
    data_ram_master_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk_i      (clk),
        .rst_ni     (clr),
        .clear_i    (accept),
        .count_en_i (state_q == RD_REQ),
        .expired_o  (expired)
    );
`else
    assign expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            rsp_rdata_q <= '0;
            wdata_q     <= '0;
            waddr_q     <= '0;
            raddr_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        req_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        waddr_q     <= req_addr;
                        raddr_q     <= req_addr;
                        wdata_q     <= req_wdata;
                        if (req_write) begin
                            we_q    <= 1'b1;
                            state_q <= WRITE;
                        end else begin
                            re_q    <= 1'b1;
                            state_q <= RD_REQ;
                        end
                    end
                end
                WRITE: begin
                    we_q        <= 1'b0;
                    rsp_rdata_q <= '0;
                    rsp_err_q   <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RD_REQ: begin
                    // A dataReady arriving on the expiry cycle still completes the load.
                    if (ram_dataReady) begin
                        state_q <= RD_CAP;
                    end else if (expired) begin
                        re_q        <= 1'b0;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                RD_CAP: begin
                    rsp_rdata_q <= ram_readData;
                    rsp_err_q   <= 1'b0;
                    re_q        <= 1'b0;
                    state_q     <= RD_REL;
                end
                RD_REL: begin
                    if (!ram_dataReady) begin
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    we_q        <= 1'b0;
                    re_q        <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready       = req_ready_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_rdata       = rsp_rdata_q;
    assign rsp_err         = rsp_err_q;
    assign busy            = busy_q;
    assign ram_writeEnable = we_q;
    assign ram_readEnable  = re_q;
    assign ram_addr        = waddr_q;
    assign ram_readAddr    = raddr_q;
    assign ram_writeData   = wdata_q;

endmodule

// File: tb/tb_data_ram_master.sv
// Directed self-checking bench for data_ram_master with a negedge-responding RAM model.
`timescale 1ns/1ps
module tb_data_ram_master;

    logic       clk = 1'b0;
    logic       clr;
    logic       req_valid, req_ready, req_write;
    logic [7:0] req_addr, req_wdata;
    logic       rsp_valid, rsp_ready, rsp_err, busy;
    logic [7:0] rsp_rdata;
    logic       ram_writeEnable, ram_readEnable;
    logic [7:0] ram_addr, ram_readAddr, ram_writeData;
    logic       ram_dataReady = 1'b0;
    logic [7:0] ram_readData = 8'h00;

    int total = 0;
    int bad = 0;
    int acceptCount = 0;
    int overlapSeen = 0;
    int ramStretch = 0;
    int stretchCnt = 0;
    bit ramMute = 1'b0;
    logic [7:0] mem [0:255];

    always #5 clk = ~clk;

    data_ram_master #(.width(8), .length(8), .TIMEOUT(16)) dut (
        .clk             (clk),
        .clr             (clr),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_rdata       (rsp_rdata),
        .rsp_err         (rsp_err),
        .busy            (busy),
        .ram_writeEnable (ram_writeEnable),
        .ram_readEnable  (ram_readEnable),
        .ram_addr        (ram_addr),
        .ram_readAddr    (ram_readAddr),
        .ram_writeData   (ram_writeData),
        .ram_dataReady   (ram_dataReady),
        .ram_readData    (ram_readData)
    );

    // RAM model: responds on negedge; ramStretch keeps dataReady high after readEnable drops.
    always @(negedge clk) begin
        if (ram_writeEnable) mem[ram_addr] <= ram_writeData;
        if (ram_readEnable && !ramMute) begin
            ram_dataReady <= 1'b1;
            ram_readData  <= mem[ram_readAddr];
            stretchCnt    <= ramStretch;
        end else if (stretchCnt > 0 && !ramMute) begin
            stretchCnt <= stretchCnt - 1;
        end else begin
            ram_dataReady <= 1'b0;
        end
        if (ram_writeEnable && ram_readEnable) overlapSeen++;
    end

    always @(posedge clk) begin
        if (req_valid && req_ready) acceptCount++;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issueReq(input bit wr, input logic [7:0] a, input logic [7:0] d);
        bit wasReady;
        int guard;
        guard = 0;
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
        do begin
            wasReady = req_ready;
            step();
            guard++;
        end while (!wasReady && guard < 50);
        req_valid = 1'b0;
    endtask

    task automatic waitRsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 100) begin
            step();
            lat++;
        end
        if (!rsp_valid) lat = -1;
    endtask

    task automatic test_reset();
        clr = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
        rsp_ready = 1'b1;
        #12;
        total++;
        if ({req_ready, rsp_valid, rsp_err, busy, ram_writeEnable, ram_readEnable} !== 6'b100000) begin
            bad++;
            $display("[TB] FAIL reset_ctrl: got %b expected 100000",
                     {req_ready, rsp_valid, rsp_err, busy, ram_writeEnable, ram_readEnable});
        end
        total++;
        if ({ram_addr, ram_readAddr, ram_writeData, rsp_rdata} !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_data: got %h expected 00000000",
                     {ram_addr, ram_readAddr, ram_writeData, rsp_rdata});
        end
        @(negedge clk) clr = 1'b1;
        step();
    endtask

    task automatic test_store_load();
        int lat;
        issueReq(1'b1, 8'h05, 8'hA5);
        total++;
        if ({ram_writeEnable, ram_readEnable} !== 2'b10) begin
            bad++; $display("[TB] FAIL store_we_on: got %b expected 10", {ram_writeEnable, ram_readEnable});
        end
        total++;
        if (ram_addr !== 8'h05 || ram_writeData !== 8'hA5) begin
            bad++; $display("[TB] FAIL store_latch: got %h/%h expected 05/a5", ram_addr, ram_writeData);
        end
        waitRsp(lat);
        total++;
        if (lat !== 1) begin bad++; $display("[TB] FAIL store_latency: got %0d expected 1", lat); end
        total++;
        if (ram_writeEnable !== 1'b0) begin bad++; $display("[TB] FAIL store_we_once: got %b expected 0", ram_writeEnable); end
        total++;
        if (rsp_rdata !== 8'h00 || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
            bad++; $display("[TB] FAIL store_rsp: got rdata=%h err=%b rdy=%b expected 00 0 0", rsp_rdata, rsp_err, req_ready);
        end
        step();
        total++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            bad++; $display("[TB] FAIL store_idle: got rdy=%b vld=%b expected 1 0", req_ready, rsp_valid);
        end
        issueReq(1'b0, 8'h05, 8'h00);
        waitRsp(lat);
        total++;
        if (lat !== 3) begin bad++; $display("[TB] FAIL load_latency: got %0d expected 3", lat); end
        total++;
        if (rsp_rdata !== 8'hA5 || rsp_err !== 1'b0) begin
            bad++; $display("[TB] FAIL load_data: got %h err=%b expected a5 0", rsp_rdata, rsp_err);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int lat;
        ramStretch = 3;
        issueReq(1'b0, 8'h00, 8'h00);
        waitRsp(lat);
        total++;
        if (lat !== 6) begin bad++; $display("[TB] FAIL b2b_lat0: got %0d expected 6", lat); end
        total++;
        if (rsp_rdata !== 8'h11 || ram_dataReady !== 1'b0) begin
            bad++; $display("[TB] FAIL b2b_data0: got %h rdy=%b expected 11 0", rsp_rdata, ram_dataReady);
        end
        step();
        issueReq(1'b0, 8'hFF, 8'h00);
        waitRsp(lat);
        total++;
        if (lat !== 6) begin bad++; $display("[TB] FAIL b2b_lat1: got %0d expected 6", lat); end
        total++;
        if (rsp_rdata !== 8'h22 || ram_dataReady !== 1'b0) begin
            bad++; $display("[TB] FAIL b2b_data1: got %h rdy=%b expected 22 0", rsp_rdata, ram_dataReady);
        end
        step();
        ramStretch = 0;
    endtask

    task automatic test_backpressure();
        int lat;
        rsp_ready = 1'b0;
        issueReq(1'b0, 8'hFF, 8'h00);
        waitRsp(lat);
        total++;
        if (lat !== 3) begin bad++; $display("[TB] FAIL bp_latency: got %0d expected 3", lat); end
        for (int i = 0; i < 5; i++) begin
            step();
            total++;
            if ({rsp_valid, req_ready, busy, rsp_err} !== 4'b1010 || rsp_rdata !== 8'h22) begin
                bad++;
                $display("[TB] FAIL bp_hold%0d: got vld/rdy/busy/err=%b rdata=%h expected 1010 22",
                         i, {rsp_valid, req_ready, busy, rsp_err}, rsp_rdata);
            end
        end
        rsp_ready = 1'b1;
        step();
        total++;
        if ({rsp_valid, req_ready, busy} !== 3'b010) begin
            bad++; $display("[TB] FAIL bp_release: got %b expected 010", {rsp_valid, req_ready, busy});
        end
    endtask

    task automatic test_reset_midway();
        int lat;
        issueReq(1'b0, 8'h05, 8'h00);
        step();
        total++;
        if (ram_readEnable !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("[TB] FAIL mid_pre: got re=%b busy=%b expected 1 1", ram_readEnable, busy);
        end
        clr = 1'b0;
        #1;
        total++;
        if ({ram_readEnable, rsp_valid, busy, req_ready} !== 4'b0001) begin
            bad++; $display("[TB] FAIL mid_reset: got %b expected 0001", {ram_readEnable, rsp_valid, busy, req_ready});
        end
        @(negedge clk) clr = 1'b1;
        step();
        issueReq(1'b0, 8'h05, 8'h00);
        waitRsp(lat);
        total++;
        if (lat !== 3 || rsp_rdata !== 8'hA5) begin
            bad++; $display("[TB] FAIL mid_reload: got lat=%0d data=%h expected 3 a5", lat, rsp_rdata);
        end
        step();
    endtask

`ifdef DATA_RAM_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        int lat;
        ramMute = 1'b1;
        issueReq(1'b0, 8'h05, 8'h00);
        waitRsp(lat);
        total++;
        if (lat !== 16) begin bad++; $display("[TB] FAIL tmo_latency: got %0d expected 16", lat); end
        total++;
        if (rsp_err !== 1'b1 || rsp_rdata !== 8'h00 || ram_readEnable !== 1'b0) begin
            bad++; $display("[TB] FAIL tmo_rsp: got err=%b data=%h re=%b expected 1 00 0", rsp_err, rsp_rdata, ram_readEnable);
        end
        step();
        ramMute = 1'b0;
    endtask
`endif

    task automatic test_held_request();
        int lat;
        int a0;
        a0 = acceptCount;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h05;
        step();
        total++;
        if (ram_readAddr !== 8'h05) begin bad++; $display("[TB] FAIL held_addr0: got %h expected 05", ram_readAddr); end
        req_addr = 8'hFF;
        step();
        total++;
        if (ram_readAddr !== 8'h05) begin bad++; $display("[TB] FAIL held_addr_busy: got %h expected 05", ram_readAddr); end
        waitRsp(lat);
        total++;
        if (rsp_rdata !== 8'hA5) begin bad++; $display("[TB] FAIL held_data0: got %h expected a5", rsp_rdata); end
        step();
        step();
        total++;
        if (ram_readAddr !== 8'hFF) begin bad++; $display("[TB] FAIL held_addr1: got %h expected ff", ram_readAddr); end
        waitRsp(lat);
        total++;
        if (rsp_rdata !== 8'h22) begin bad++; $display("[TB] FAIL held_data1: got %h expected 22", rsp_rdata); end
        req_valid = 1'b0;
        step();
        step();
        total++;
        if (acceptCount - a0 !== 2 || busy !== 1'b0) begin
            bad++; $display("[TB] FAIL held_accepts: got %0d busy=%b expected 2 0", acceptCount - a0, busy);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h11;
        mem[8'hFF] = 8'h22;
        test_reset();
        test_store_load();
        test_back_to_back();
        test_backpressure();
        test_reset_midway();
`ifdef DATA_RAM_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        test_held_request();
        total++;
        if (overlapSeen !== 0) begin bad++; $display("[TB] FAIL enable_overlap: got %0d expected 0", overlapSeen); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
